// File: rtl/pipeline_hazard_scheduler_if.sv
// Decode-side handshake between the decoder/fetch logic and the hazard scheduler.
// The scheduler sits on the slave side; the decoder (or a bench) is the master.
interface pipeline_hazard_scheduler_if;
    logic [4:0]  dec_src0;
    logic        dec_src0_en;
    logic [4:0]  dec_src1;
    logic        dec_src1_en;
    logic [4:0]  dec_dst;
    logic        dec_dst_en;
    logic        dec_is_jump;
    logic        jump_taken;
    logic        pc_en;
    logic        pc_sel_jump;
    logic        issue_reg_en;
    logic        dec_valid;
    logic        stall;
    logic        exe_valid;
    logic        mem_valid;
    logic        wb_valid;
    logic        wb_write_en;
    logic [31:0] stall_cycles;

    modport master (
        output dec_src0, dec_src0_en, dec_src1, dec_src1_en,
               dec_dst, dec_dst_en, dec_is_jump, jump_taken,
        input  pc_en, pc_sel_jump, issue_reg_en, dec_valid, stall,
               exe_valid, mem_valid, wb_valid, wb_write_en, stall_cycles
    );

    modport slave (
        input  dec_src0, dec_src0_en, dec_src1, dec_src1_en,
               dec_dst, dec_dst_en, dec_is_jump, jump_taken,
        output pc_en, pc_sel_jump, issue_reg_en, dec_valid, stall,
               exe_valid, mem_valid, wb_valid, wb_write_en, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_scheduler.sv
// Five-stage pipeline sequencer: tracks EXE/MEM/WB occupancy, stalls decode on
// RAW hazards against in-flight destinations and squashes on taken jumps.
module pipeline_hazard_scheduler #(
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_scheduler_if.slave   bus
);

    logic        iv;
    logic        vld_p0, vld_p1, vld_p2;
    logic [4:0]  dst_p0, dst_p1, dst_p2;
    logic        dst_en_p0, dst_en_p1, dst_en_p2;
    logic        jmp_p0;
    logic [31:0] stall_cnt;

    logic        hit_p0, hit_p1, hit_p2;
    logic        redirect;
    logic        stall;

    // Does the decode instruction read the given in-flight destination?
    function automatic logic reads_reg(input logic [4:0] dst,
                                       input logic       s0_en, input logic [4:0] s0,
                                       input logic       s1_en, input logic [4:0] s1);
        return (s0_en && (s0 == dst)) || (s1_en && (s1 == dst));
    endfunction

    // Debug counter wraps silently rather than saturating.
    function automatic logic [31:0] cnt_inc(input logic [31:0] c);
        return c + 32'd1;
    endfunction

    always_comb begin
        hit_p0 = vld_p0 && dst_en_p0 &&
                 reads_reg(dst_p0, bus.dec_src0_en, bus.dec_src0, bus.dec_src1_en, bus.dec_src1);
        hit_p1 = vld_p1 && dst_en_p1 &&
                 reads_reg(dst_p1, bus.dec_src0_en, bus.dec_src0, bus.dec_src1_en, bus.dec_src1);
        hit_p2 = !WB_BYPASS && vld_p2 && dst_en_p2 &&
                 reads_reg(dst_p2, bus.dec_src0_en, bus.dec_src0, bus.dec_src1_en, bus.dec_src1);
        redirect = vld_p0 && jmp_p0 && bus.jump_taken;
        // A taken jump squashes the decode slot, so it must never also be held.
        stall    = iv && (hit_p0 || hit_p1 || hit_p2) && !redirect;
    end

    assign bus.pc_en        = !stall;
    assign bus.pc_sel_jump  = redirect;
    assign bus.issue_reg_en = !stall;
    assign bus.dec_valid    = iv;
    assign bus.stall        = stall;
    assign bus.exe_valid    = vld_p0;
    assign bus.mem_valid    = vld_p1;
    assign bus.wb_valid     = vld_p2;
    assign bus.wb_write_en  = vld_p2 && dst_en_p2;
    assign bus.stall_cycles = stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iv        <= 1'b0;
            vld_p0    <= 1'b0;
            dst_p0    <= 5'd0;
            dst_en_p0 <= 1'b0;
            jmp_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            dst_p1    <= 5'd0;
            dst_en_p1 <= 1'b0;
            vld_p2    <= 1'b0;
            dst_p2    <= 5'd0;
            dst_en_p2 <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            // Decode -> EXE
            if (redirect)
                iv <= 1'b0;
            else if (!stall)
                iv <= 1'b1;
            vld_p0    <= iv && !stall && !redirect;
            dst_p0    <= bus.dec_dst;
            dst_en_p0 <= bus.dec_dst_en;
            jmp_p0    <= bus.dec_is_jump;
            // EXE -> MEM
            vld_p1    <= vld_p0;
            dst_p1    <= dst_p0;
            dst_en_p1 <= dst_en_p0;
            // MEM -> WB
            vld_p2    <= vld_p1;
            dst_p2    <= dst_p1;
            dst_en_p2 <= dst_en_p1;
            if (stall)
                stall_cnt <= cnt_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Directed bench for pipeline_hazard_scheduler; dut0 has WB_BYPASS=0, dut1 has WB_BYPASS=1.
module tb_pipeline_hazard_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [4:0] src0, src1, dst;
    logic       src0_en, src1_en, dst_en, is_jump, jt;

    pipeline_hazard_scheduler_if bus0 ();
    pipeline_hazard_scheduler_if bus1 ();

    pipeline_hazard_scheduler #(.WB_BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipeline_hazard_scheduler #(.WB_BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.dec_src0 = src0;  assign bus1.dec_src0 = src0;
    assign bus0.dec_src0_en = src0_en;  assign bus1.dec_src0_en = src0_en;
    assign bus0.dec_src1 = src1;  assign bus1.dec_src1 = src1;
    assign bus0.dec_src1_en = src1_en;  assign bus1.dec_src1_en = src1_en;
    assign bus0.dec_dst = dst;  assign bus1.dec_dst = dst;
    assign bus0.dec_dst_en = dst_en;  assign bus1.dec_dst_en = dst_en;
    assign bus0.dec_is_jump = is_jump;  assign bus1.dec_is_jump = is_jump;
    assign bus0.jump_taken = jt;  assign bus1.jump_taken = jt;

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        src0 = 5'd0; src0_en = 1'b0; src1 = 5'd0; src1_en = 1'b0;
        dst = 5'd0; dst_en = 1'b0; is_jump = 1'b0; jt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; the edge after release is edge 1.
    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic check_in_reset(input string pfx);
        chk1({pfx, "_pc_en"}, bus0.pc_en, 1'b1);
        chk1({pfx, "_issue_en"}, bus0.issue_reg_en, 1'b1);
        chk1({pfx, "_stall"}, bus0.stall, 1'b0);
        chk1({pfx, "_sel_jump"}, bus0.pc_sel_jump, 1'b0);
        chk1({pfx, "_dec_valid"}, bus0.dec_valid, 1'b0);
        chk1({pfx, "_exe_valid"}, bus0.exe_valid, 1'b0);
        chk1({pfx, "_mem_valid"}, bus0.mem_valid, 1'b0);
        chk1({pfx, "_wb_valid"}, bus0.wb_valid, 1'b0);
        chk1({pfx, "_wb_we"}, bus0.wb_write_en, 1'b0);
        chk32({pfx, "_stall_cycles"}, bus0.stall_cycles, 32'd0);
    endtask

    task automatic check_startup(input string pfx);
        tick();
        chk1({pfx, "_e1_dec_valid"}, bus0.dec_valid, 1'b1);
        chk1({pfx, "_e1_exe_valid"}, bus0.exe_valid, 1'b0);
        tick();
        chk1({pfx, "_e2_exe_valid"}, bus0.exe_valid, 1'b1);
        chk1({pfx, "_e2_mem_valid"}, bus0.mem_valid, 1'b0);
        tick();
        chk1({pfx, "_e3_mem_valid"}, bus0.mem_valid, 1'b1);
        chk1({pfx, "_e3_wb_valid"}, bus0.wb_valid, 1'b0);
        tick();
        chk1({pfx, "_e4_wb_valid"}, bus0.wb_valid, 1'b1);
        chk32({pfx, "_stall_cycles"}, bus0.stall_cycles, 32'd0);
    endtask

    initial begin
        idle();
        // Scenario 1: reset, then hazard-free startup.
        #3;
        check_in_reset("rst");
        @(negedge clk);
        rst = 1'b1;
        check_startup("start");

        // Scenario 2: producer writes r3, consumer reads r3 via src0 (both variants).
        do_reset();
        tick();
        dst = 5'd3; dst_en = 1'b1;
        #1 chk1("raw_prod_no_stall", bus0.stall, 1'b0);
        tick();
        chk1("raw_prod_in_exe", bus0.exe_valid, 1'b1);
        idle(); src0 = 5'd3; src0_en = 1'b1;
        #1;
        chk1("raw_c1_stall0", bus0.stall, 1'b1);
        chk1("raw_c1_pc_en0", bus0.pc_en, 1'b0);
        chk1("raw_c1_issue0", bus0.issue_reg_en, 1'b0);
        chk1("raw_c1_stall1", bus1.stall, 1'b1);
        tick();
        chk1("raw_c2_stall0", bus0.stall, 1'b1);
        chk1("raw_c2_bubble0", bus0.exe_valid, 1'b0);
        chk1("raw_c2_stall1", bus1.stall, 1'b1);
        tick();
        chk1("raw_c3_stall0", bus0.stall, 1'b1);
        chk1("raw_c3_pc_en0", bus0.pc_en, 1'b0);
        chk1("raw_c3_bubble0", bus0.exe_valid, 1'b0);
        chk1("raw_c3_wb_we0", bus0.wb_write_en, 1'b1);
        chk1("raw_c3_stall1", bus1.stall, 1'b0);
        tick();
        chk1("raw_c4_stall0", bus0.stall, 1'b0);
        chk1("raw_c4_bubble0", bus0.exe_valid, 1'b0);
        chk1("raw_c4_cons_exe1", bus1.exe_valid, 1'b1);
        idle();
        tick();
        chk1("raw_cons_exe0", bus0.exe_valid, 1'b1);
        chk32("raw_stall_cycles0", bus0.stall_cycles, 32'd3);
        chk32("raw_stall_cycles1", bus1.stall_cycles, 32'd2);

        // Scenario 3: r3 in flight but src1 read disabled.
        do_reset();
        tick();
        dst = 5'd3; dst_en = 1'b1;
        tick();
        idle(); src1 = 5'd3; src1_en = 1'b0; src0 = 5'd5; src0_en = 1'b1;
        #1 chk1("src1dis_stall_a", bus0.stall, 1'b0);
        tick();
        chk1("src1dis_stall_b", bus0.stall, 1'b0);
        tick();
        chk1("src1dis_stall_c", bus0.stall, 1'b0);
        chk32("src1dis_stall_cycles", bus0.stall_cycles, 32'd0);

        // Scenario 4: taken jump, then a not-taken jump.
        do_reset();
        tick();
        is_jump = 1'b1;
        #1 chk1("jmp_dec_no_sel", bus0.pc_sel_jump, 1'b0);
        tick();
        chk1("jmp_in_exe", bus0.exe_valid, 1'b1);
        idle(); jt = 1'b1;
        #1;
        chk1("jmp_sel", bus0.pc_sel_jump, 1'b1);
        chk1("jmp_pc_en", bus0.pc_en, 1'b1);
        chk1("jmp_stall", bus0.stall, 1'b0);
        tick();
        chk1("jmp_r1_dec_valid", bus0.dec_valid, 1'b0);
        chk1("jmp_r1_bubble", bus0.exe_valid, 1'b0);
        chk1("jmp_r1_sel", bus0.pc_sel_jump, 1'b0);
        jt = 1'b0;
        tick();
        chk1("jmp_r2_dec_valid", bus0.dec_valid, 1'b1);
        chk1("jmp_r2_bubble", bus0.exe_valid, 1'b0);
        tick();
        chk1("jmp_target_exe", bus0.exe_valid, 1'b1);
        is_jump = 1'b1;
        tick();
        idle();
        #1 chk1("nt_sel", bus0.pc_sel_jump, 1'b0);
        tick();
        chk1("nt_next_exe", bus0.exe_valid, 1'b1);
        chk1("nt_dec_valid", bus0.dec_valid, 1'b1);
        tick();
        chk1("nt_next2_exe", bus0.exe_valid, 1'b1);

        // Scenario 5: RAW on a MEM-stage register while a taken jump is in EXE.
        do_reset();
        tick();
        dst = 5'd7; dst_en = 1'b1;
        tick();
        idle(); is_jump = 1'b1;
        #1 chk1("hz_jmp_dec_stall", bus0.stall, 1'b0);
        tick();
        idle(); src0 = 5'd7; src0_en = 1'b1; jt = 1'b1;
        #1;
        chk1("hz_redir_stall", bus0.stall, 1'b0);
        chk1("hz_redir_sel", bus0.pc_sel_jump, 1'b1);
        chk1("hz_redir_pc_en", bus0.pc_en, 1'b1);
        tick();
        chk1("hz_squash_exe_a", bus0.exe_valid, 1'b0);
        chk1("hz_squash_dec", bus0.dec_valid, 1'b0);
        idle();
        tick();
        chk1("hz_squash_exe_b", bus0.exe_valid, 1'b0);
        chk32("hz_stall_cycles", bus0.stall_cycles, 32'd0);

        // Scenario 6: reset asserted in the second cycle of a 3-cycle stall.
        do_reset();
        tick();
        dst = 5'd3; dst_en = 1'b1;
        tick();
        idle(); src0 = 5'd3; src0_en = 1'b1;
        tick();
        chk1("mid_pre_stall", bus0.stall, 1'b1);
        chk32("mid_pre_cycles", bus0.stall_cycles, 32'd1);
        #2 rst = 1'b0;
        #1 check_in_reset("mid_rst");
        idle();
        @(negedge clk);
        rst = 1'b1;
        check_startup("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
